// File: rtl/uart_pkg.sv
// uart_pkg
//   Definitions shared by the UART receive and transmit controllers:
//   one-hot frame state encodings, the legal oversampling ratios and a
//   helper that maps any prescale request onto a legal ratio.
package uart_pkg;

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        START  = 5'b00010,
        DATA   = 5'b00100,
        PARITY = 5'b01000,
        STOP   = 5'b10000
    } uart_state_e;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    // Anything other than 16 or 32 falls back to 8x oversampling.
    function automatic logic [5:0] legal_prescale(input logic [5:0] p);
        logic [5:0] r;
        case (p)
            PRESCALE_16: r = PRESCALE_16;
            PRESCALE_32: r = PRESCALE_32;
            default:     r = PRESCALE_8;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if
//   Serial line, frame configuration and received-data signals of the
//   UART receiver.
//   master : drives RX_IN, PAR_EN, PAR_TYP, Prescale; observes results
//   slave  : the receiver; drives P_DATA, data_valid, parity_error,
//            stop_error
interface uart_rx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  RX_IN;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [5:0]            Prescale;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  parity_error;
    logic                  stop_error;

    modport master (
        output RX_IN, PAR_EN, PAR_TYP, Prescale,
        input  P_DATA, data_valid, parity_error, stop_error
    );

    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP, Prescale,
        output P_DATA, data_valid, parity_error, stop_error
    );
endinterface

// File: rtl/rx_edge_bit_counter.sv
// rx_edge_bit_counter
//   Oversampling edge counter and data-bit counter for the UART receiver.
//   Ports:
//     clk, rst   : clock, asynchronous active-high reset
//     cnt_start  : start bit seen in idle; this cycle is edge 0
//     cnt_en     : a frame is in progress
//     bit_en     : the data-bit counter advances on each edge wrap
//     edge_max   : last edge index of a bit (latched prescale - 1)
//     edge_cnt   : current edge index within the bit
//     edge_last  : edge_cnt is at edge_max
//     bit_last   : data-bit counter is at DATA_WIDTH-1
module rx_edge_bit_counter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cnt_start,
    input  logic       cnt_en,
    input  logic       bit_en,
    input  logic [5:0] edge_max,
    output logic [5:0] edge_cnt,
    output logic       edge_last,
    output logic       bit_last
);
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0] BIT_ONE = BIT_W'(1);

    logic [5:0]       edge_cnt_q, edge_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;

    assign edge_cnt  = edge_cnt_q;
    assign edge_last = (edge_cnt_q == edge_max);
    assign bit_last  = (bit_cnt_q == BIT_MAX);

    always_comb begin
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        if (cnt_start) begin
            // The detecting cycle already counts as edge 0.
            edge_cnt_d = 6'd1;
            bit_cnt_d  = '0;
        end else if (cnt_en) begin
            if (edge_last) begin
                edge_cnt_d = '0;
                if (bit_en) begin
                    bit_cnt_d = bit_last ? '0 : bit_cnt_q + BIT_ONE;
                end
            end else begin
                edge_cnt_d = edge_cnt_q + 6'd1;
            end
        end else begin
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
//   UART receive controller: start detection, 3-sample majority voting,
//   LSB-first deserialisation, optional even/odd parity check, stop check.
//   Ports:
//     clk : oversampling clock (Prescale x bit rate)
//     rst : asynchronous active-high reset
//     rx  : slave side of uart_rx_ctrl_if (RX_IN, PAR_EN, PAR_TYP,
//           Prescale in; P_DATA, data_valid, parity_error, stop_error out)
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_ctrl_if.slave rx
);
    uart_state_e           state_q, state_d;
    logic [5:0]            p_q, p_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic [1:0]            samp_q, samp_d;
    logic                  bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  frame_err_q, frame_err_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  parity_error_q, parity_error_d;
    logic                  stop_error_q, stop_error_d;

    logic [5:0] edge_cnt;
    logic       edge_last, bit_last;
    logic       cnt_start, cnt_en, bit_en;
    logic [5:0] edge_max, samp_lo, samp_mid, samp_hi;

    assign edge_max = p_q - 6'd1;
    assign samp_mid = p_q >> 1;
    assign samp_lo  = samp_mid - 6'd1;
    assign samp_hi  = samp_mid + 6'd1;

    assign cnt_start = (state_q == IDLE) && !rx.RX_IN;
    assign cnt_en    = (state_q != IDLE);
    assign bit_en    = (state_q == DATA);

    rx_edge_bit_counter #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .cnt_start (cnt_start),
        .cnt_en    (cnt_en),
        .bit_en    (bit_en),
        .edge_max  (edge_max),
        .edge_cnt  (edge_cnt),
        .edge_last (edge_last),
        .bit_last  (bit_last)
    );

    always_comb begin
        state_d        = state_q;
        p_d            = p_q;
        par_en_d       = par_en_q;
        par_typ_d      = par_typ_q;
        samp_d         = samp_q;
        bit_d          = bit_q;
        shift_d        = shift_q;
        frame_err_d    = frame_err_q;
        p_data_d       = p_data_q;
        data_valid_d   = 1'b0;
        parity_error_d = 1'b0;
        stop_error_d   = 1'b0;

        // Majority vote resolves on the third sample; bit_q is then stable
        // until the bit's last edge, where the FSM consumes it.
        if (state_q != IDLE) begin
            if (edge_cnt == samp_lo)  samp_d[0] = rx.RX_IN;
            if (edge_cnt == samp_mid) samp_d[1] = rx.RX_IN;
            if (edge_cnt == samp_hi) begin
                bit_d = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx.RX_IN) |
                        (samp_q[1] & rx.RX_IN);
            end
        end

        case (state_q)
            IDLE: begin
                if (!rx.RX_IN) begin
                    state_d     = START;
                    p_d         = legal_prescale(rx.Prescale);
                    par_en_d    = rx.PAR_EN;
                    par_typ_d   = rx.PAR_TYP;
                    frame_err_d = 1'b0;
                end
            end
            START: begin
                if (edge_last) state_d = bit_q ? IDLE : DATA;
            end
            DATA: begin
                if (edge_last) begin
                    shift_d = {bit_q, shift_q[DATA_WIDTH-1:1]};
                    if (bit_last) state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (edge_last) begin
                    if (bit_q != ((^shift_q) ^ par_typ_q)) begin
                        parity_error_d = 1'b1;
                        frame_err_d    = 1'b1;
                    end
                    state_d = STOP;
                end
            end
            STOP: begin
                if (edge_last) begin
                    state_d = IDLE;
                    if (!bit_q) begin
                        stop_error_d = 1'b1;
                    end else if (!frame_err_q) begin
                        data_valid_d = 1'b1;
                        p_data_d     = shift_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            p_q            <= PRESCALE_8;
            par_en_q       <= 1'b0;
            par_typ_q      <= 1'b0;
            samp_q         <= '0;
            bit_q          <= 1'b0;
            shift_q        <= '0;
            frame_err_q    <= 1'b0;
            p_data_q       <= '0;
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            p_q            <= p_d;
            par_en_q       <= par_en_d;
            par_typ_q      <= par_typ_d;
            samp_q         <= samp_d;
            bit_q          <= bit_d;
            shift_q        <= shift_d;
            frame_err_q    <= frame_err_d;
            p_data_q       <= p_data_d;
            data_valid_q   <= data_valid_d;
            parity_error_q <= parity_error_d;
            stop_error_q   <= stop_error_d;
        end
    end

    assign rx.P_DATA       = p_data_q;
    assign rx.data_valid   = data_valid_q;
    assign rx.parity_error = parity_error_q;
    assign rx.stop_error   = stop_error_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl
//   Directed bench for uart_rx_ctrl: a vector table of whole frames plus
//   hand-written sequences for start glitch, back-to-back frames and
//   reset in the middle of a frame. Pulse times are measured in cycles
//   from the first cycle the line is driven low.
module tb_uart_rx_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   cyc;
    int   checks = 0;
    int   errors = 0;

    uart_rx_ctrl_if #(.DATA_WIDTH(8)) bus ();

    uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse log: absolute cycle of every output pulse seen.
    int          dv_q[$];
    logic [7:0]  dvd_q[$];
    int          pe_q[$];
    int          se_q[$];

    always @(negedge clk) begin
        if (bus.data_valid) begin
            dv_q.push_back(cyc);
            dvd_q.push_back(bus.P_DATA);
        end
        if (bus.parity_error) pe_q.push_back(cyc);
        if (bus.stop_error)   se_q.push_back(cyc);
    end

    typedef struct {
        logic [5:0] presc;
        int         bp;
        bit         pen;
        bit         ptyp;
        logic [7:0] data;
        bit         pbit;
        bit         sbit;
        int         gbit;
        int         gedge;
        bit         chg;
        bit         exp_dv;
        bit         exp_pe;
        bit         exp_se;
        logic [7:0] exp_pd;
        int         exp_lat;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame, bp cycles per bit. gbit/gedge invert a single cycle
    // of one frame bit; chg alters the configuration inputs mid-frame; cut
    // stops after that many cycles (-1 for the whole frame).
    task automatic send_frame(input logic [7:0] data, input int bp, input bit pen,
                              input bit pbit, input bit sbit, input int gbit,
                              input int gedge, input bit chg, input int cut);
        logic fb [0:10];
        int   nb;
        int   sent = 0;
        nb = pen ? 11 : 10;
        fb[0] = 1'b0;
        for (int k = 0; k < 8; k++) fb[k+1] = data[k];
        fb[9]  = pen ? pbit : sbit;
        fb[10] = sbit;
        for (int b = 0; b < nb; b++) begin
            for (int e = 0; e < bp; e++) begin
                if (cut >= 0 && sent == cut) return;
                bus.RX_IN = fb[b] ^ ((b == gbit && e == gedge) ? 1'b1 : 1'b0);
                if (chg && b == 1 && e == 0) begin
                    bus.Prescale = 6'd16;
                    bus.PAR_EN   = 1'b1;
                    bus.PAR_TYP  = 1'b1;
                end
                @(posedge clk);
                #1;
                sent++;
            end
        end
    endtask

    int n_dv, n_pe, n_se, t0;

    initial begin
        //            presc  bp  pen   ptyp  data   pbit  sbit  gb  ge  chg   dv    pe    se    pd     lat
        vecs[0]  = '{6'd8,   8, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, -1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5,  80};
        vecs[1]  = '{6'd16, 16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, -1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 176};
        vecs[2]  = '{6'd16, 16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, -1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 160};
        vecs[3]  = '{6'd8,   8, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C,  80};
        vecs[4]  = '{6'd32, 32, 1'b1, 1'b1, 8'h07, 1'b0, 1'b1, -1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h07, 352};
        vecs[5]  = '{6'd32, 32, 1'b1, 1'b1, 8'h01, 1'b1, 1'b1, -1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h07, 320};
        vecs[6]  = '{6'd12,  8, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, -1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hC3,  80};
        vecs[7]  = '{6'd0,   8, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1, -1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01,  88};
        vecs[8]  = '{6'd16, 16, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 160};
        vecs[9]  = '{6'd8,   8, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1,  1, 4, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00,  80};
        vecs[10] = '{6'd8,   8, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1,  0, 4, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A,  80};
        vecs[11] = '{6'd8,   8, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, -1, 0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h96,  80};
        vecs[12] = '{6'd63,  8, 1'b1, 1'b0, 8'h80, 1'b1, 1'b1, -1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h80,  88};

        rst          = 1'b1;
        bus.RX_IN    = 1'b1;
        bus.PAR_EN   = 1'b0;
        bus.PAR_TYP  = 1'b0;
        bus.Prescale = 6'd8;
        idle(3);
        check("reset_pdata", int'(bus.P_DATA), 0);
        check("reset_dv", int'(bus.data_valid), 0);
        check("reset_pe", int'(bus.parity_error), 0);
        check("reset_se", int'(bus.stop_error), 0);
        rst = 1'b0;
        idle(3);

        for (int i = 0; i < 13; i++) begin
            bus.Prescale = vecs[i].presc;
            bus.PAR_EN   = vecs[i].pen;
            bus.PAR_TYP  = vecs[i].ptyp;
            bus.RX_IN    = 1'b1;
            idle(3);
            n_dv = dv_q.size();
            n_pe = pe_q.size();
            n_se = se_q.size();
            t0   = cyc;
            send_frame(vecs[i].data, vecs[i].bp, vecs[i].pen, vecs[i].pbit, vecs[i].sbit,
                       vecs[i].gbit, vecs[i].gedge, vecs[i].chg, -1);
            bus.RX_IN = 1'b1;
            idle(6);
            check($sformatf("v%0d_dv_cnt", i), dv_q.size() - n_dv, int'(vecs[i].exp_dv));
            check($sformatf("v%0d_pe_cnt", i), pe_q.size() - n_pe, int'(vecs[i].exp_pe));
            check($sformatf("v%0d_se_cnt", i), se_q.size() - n_se, int'(vecs[i].exp_se));
            if (vecs[i].exp_dv && dv_q.size() > n_dv)
                check($sformatf("v%0d_dv_lat", i), dv_q[n_dv] - t0, vecs[i].exp_lat);
            if (vecs[i].exp_pe && pe_q.size() > n_pe)
                check($sformatf("v%0d_pe_lat", i), pe_q[n_pe] - t0, vecs[i].exp_lat);
            if (vecs[i].exp_se && se_q.size() > n_se)
                check($sformatf("v%0d_se_lat", i), se_q[n_se] - t0, vecs[i].exp_lat);
            check($sformatf("v%0d_pdata", i), int'(bus.P_DATA), int'(vecs[i].exp_pd));
        end

        // Start-bit glitch at 32x: three low cycles only.
        bus.Prescale = 6'd32;
        bus.PAR_EN   = 1'b0;
        bus.PAR_TYP  = 1'b0;
        idle(3);
        n_dv = dv_q.size();
        n_pe = pe_q.size();
        n_se = se_q.size();
        bus.RX_IN = 1'b0;
        idle(3);
        bus.RX_IN = 1'b1;
        idle(40);
        check("glitch_dv", dv_q.size() - n_dv, 0);
        check("glitch_pe", pe_q.size() - n_pe, 0);
        check("glitch_se", se_q.size() - n_se, 0);
        t0 = cyc;
        send_frame(8'h81, 32, 1'b0, 1'b0, 1'b1, -1, 0, 1'b0, -1);
        bus.RX_IN = 1'b1;
        idle(6);
        check("glitch_next_cnt", dv_q.size() - n_dv, 1);
        if (dv_q.size() > n_dv) check("glitch_next_lat", dv_q[n_dv] - t0, 320);
        check("glitch_next_pdata", int'(bus.P_DATA), 8'h81);

        // Back-to-back frames with no idle gap.
        bus.Prescale = 6'd8;
        idle(3);
        n_dv = dv_q.size();
        t0   = cyc;
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, -1, 0, 1'b0, -1);
        send_frame(8'hAA, 8, 1'b0, 1'b0, 1'b1, -1, 0, 1'b0, -1);
        bus.RX_IN = 1'b1;
        idle(6);
        check("b2b_cnt", dv_q.size() - n_dv, 2);
        if (dv_q.size() >= n_dv + 2) begin
            check("b2b_lat0", dv_q[n_dv] - t0, 80);
            check("b2b_lat1", dv_q[n_dv+1] - t0, 160);
            check("b2b_data0", int'(dvd_q[n_dv]), 8'h55);
            check("b2b_data1", int'(dvd_q[n_dv+1]), 8'hAA);
        end
        check("b2b_pdata", int'(bus.P_DATA), 8'hAA);

        // Reset during data bit 4 at 16x, then a clean frame.
        bus.Prescale = 6'd16;
        idle(3);
        n_dv = dv_q.size();
        n_pe = pe_q.size();
        n_se = se_q.size();
        send_frame(8'h33, 16, 1'b0, 1'b0, 1'b1, -1, 0, 1'b0, 85);
        rst       = 1'b1;
        bus.RX_IN = 1'b1;
        #1;
        check("midrst_pdata", int'(bus.P_DATA), 0);
        idle(3);
        rst = 1'b0;
        idle(200);
        check("midrst_dv", dv_q.size() - n_dv, 0);
        check("midrst_pe", pe_q.size() - n_pe, 0);
        check("midrst_se", se_q.size() - n_se, 0);
        t0 = cyc;
        send_frame(8'h0F, 16, 1'b0, 1'b0, 1'b1, -1, 0, 1'b0, -1);
        bus.RX_IN = 1'b1;
        idle(6);
        check("midrst_next_cnt", dv_q.size() - n_dv, 1);
        if (dv_q.size() > n_dv) check("midrst_next_lat", dv_q[n_dv] - t0, 160);
        check("midrst_next_pdata", int'(bus.P_DATA), 8'h0F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, number of data bits per frame.
REQ-002 Port: clk  input  1  single clock, oversampling clock (Prescale x bit rate).
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: RX_IN  input  1  serial line, idle high, already synchronised to clk.
REQ-005 Port: PAR_EN  input  1  1 = frame carries a parity bit.
REQ-006 Port: PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-007 Port: Prescale  input  6  oversampling ratio; legal values are 8, 16 and 32.
REQ-008 Port: P_DATA  output  DATA_WIDTH  last good received byte, registered.
REQ-009 Port: data_valid  output  1  one-cycle pulse when P_DATA holds a new error-free frame.
REQ-010 Port: parity_error  output  1  one-cycle pulse when the parity bit mismatches.
REQ-011 Port: stop_error  output  1  one-cycle pulse when the stop bit is sampled low.

Function
REQ-012 Frame format: start(0), DATA_WIDTH data bits LSB first, optional parity, one stop(1).
REQ-013 The state machine SHALL use the states IDLE, START, DATA, PARITY and STOP, one-hot encoded.
REQ-014 IDLE: when RX_IN=0 is seen, the block SHALL go to START and latch PAR_EN, PAR_TYP and Prescale for the whole frame; that cycle is edge 0 of the start bit.
REQ-015 Within each bit, edge_cnt SHALL count 0..P-1, where P is the latched Prescale; bit_cnt SHALL advance when edge_cnt wraps.
REQ-016 Each bit value SHALL be the majority of 3 samples taken at edge_cnt = P/2-1, P/2 and P/2+1.
REQ-017 START: at edge P-1, a sampled 1 (glitch) SHALL return to IDLE with no output pulse; a sampled 0 SHALL go to DATA.
REQ-018 DATA: each sampled bit SHALL be shifted into the internal shift register LSB first; after bit DATA_WIDTH-1 ends, go to PARITY if PAR_EN=1, else STOP.
REQ-019 PARITY: expected value is XOR of the data bits (even) or its inverse (odd); at edge P-1 of the parity bit, a mismatch SHALL pulse parity_error for 1 cycle.
REQ-020 STOP: at edge P-1 of the stop bit, a sampled 0 SHALL pulse stop_error for 1 cycle; the machine SHALL then return to IDLE.
REQ-021 On the cycle after stop-bit edge P-1, if neither error occurred in the frame, P_DATA SHALL be updated and data_valid SHALL pulse in the same cycle.
REQ-022 On an errored frame, P_DATA SHALL keep its old value and data_valid SHALL stay 0.
REQ-023 Latency: data_valid SHALL be asserted N*P cycles after the first low sample, where N = DATA_WIDTH+2, plus 1 if parity is enabled.
REQ-024 Back-to-back frames: IDLE SHALL detect a new start bit in the first cycle after the stop bit, with no gap cycles required.
REQ-025 Illegal Prescale values (anything other than 8, 16 or 32) SHALL be treated as 8.
REQ-026 Changes on Prescale, PAR_EN or PAR_TYP during a frame SHALL NOT affect that frame.
REQ-027 Counters SHALL wrap only under state control, and SHALL never exceed P-1 or DATA_WIDTH-1.

Reset
REQ-028 While rst=1: state = IDLE, counters = 0, shift register = 0, P_DATA = 0, data_valid = 0, parity_error = 0, stop_error = 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no pulse; after release the block SHALL wait in IDLE for a new falling edge.

Structure
REQ-030 The shared package uart_pkg SHALL hold the state encodings and the legal prescale constants (8, 16, 32); the TX side SHALL use the same package.
REQ-031 Edge and bit counting SHALL live in one sub-module, rx_edge_bit_counter; sampling, shifting, parity and the FSM SHALL stay in uart_rx_ctrl.

Verification
REQ-032 Prescale=8, PAR_EN=0, frame 0xA5 -> data_valid pulses exactly 80 cycles after the start edge, P_DATA=0xA5, no error pulses.
REQ-033 Prescale=16, PAR_EN=1, PAR_TYP=0, frame 0x3C with parity bit 0 -> P_DATA=0x3C, data_valid at cycle 176; the same frame with parity bit 1 -> parity_error pulse, no data_valid, P_DATA unchanged.
REQ-034 Prescale=8, stop bit driven 0 -> stop_error pulse at stop-bit edge 7, no data_valid, P_DATA unchanged.
REQ-035 Prescale=32, RX_IN low for 3 cycles then high (glitch) -> return to IDLE, no pulses; a following valid frame 0x81 -> P_DATA=0x81.
REQ-036 Two back-to-back frames 0x55 then 0xAA, Prescale=8, no gap -> two data_valid pulses 80 cycles apart with the correct data.
REQ-037 Prescale=16, rst pulsed during data bit 4, then frame 0x0F -> no pulse from the aborted frame, then P_DATA=0x0F.
